// File: rtl/axi_lite_wr_switch_3to1.sv
// ---------------------------------------------------------------------------
// axi_lite_wr_switch_3to1
//
// Connects three AXI4-Lite write masters to one slave. Arbitration is fixed
// priority on m_awvalid: master 0 wins over master 1, and master 1 wins over
// master 2. The winner is registered into a one-hot grant. AW, W and B then
// stay locked to that master until its write response handshakes. Exactly
// one AW beat and one W beat are forwarded per grant.
//
// Ports
//   ACLK, ARESETN                    clock, asynchronous active-low reset
//   m_awaddr/m_awvalid/m_awready     master AW channels (slice i = master i)
//   m_wdata/m_wstrb/m_wvalid/m_wready master W channels
//   m_bresp                          B response broadcast to all masters
//   m_bvalid/m_bready                per-master B handshake
//   s_aw*/s_w*/s_b*                  single slave-side write channels
//   grant                            registered one-hot lock, 000 when idle
//   busy                             high whenever a write is in progress
// ---------------------------------------------------------------------------
module axi_lite_wr_switch_3to1 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [3*ADDR_W-1:0]     m_awaddr,
  input  logic [2:0]              m_awvalid,
  output logic [2:0]              m_awready,
  input  logic [3*DATA_W-1:0]     m_wdata,
  input  logic [3*(DATA_W/8)-1:0] m_wstrb,
  input  logic [2:0]              m_wvalid,
  output logic [2:0]              m_wready,
  output logic [1:0]              m_bresp,
  output logic [2:0]              m_bvalid,
  input  logic [2:0]              m_bready,
  output logic [ADDR_W-1:0]       s_awaddr,
  output logic                    s_awvalid,
  input  logic                    s_awready,
  output logic [DATA_W-1:0]       s_wdata,
  output logic [DATA_W/8-1:0]     s_wstrb,
  output logic                    s_wvalid,
  input  logic                    s_wready,
  input  logic [1:0]              s_bresp,
  input  logic                    s_bvalid,
  output logic                    s_bready,
  output logic [2:0]              grant,
  output logic                    busy
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] grant_nxt;
  logic       aw_done, aw_done_nxt;
  logic       w_done, w_done_nxt;
  logic       aw_fin, w_fin;
  logic [1:0] g_idx;

  // Lowest-index requester wins. Masters 1 and 2 can starve.
  function automatic logic [2:0] pick_winner(input logic [2:0] req);
    logic [2:0] win;
    win = 3'b000;
    if (req[0])      win = 3'b001;
    else if (req[1]) win = 3'b010;
    else if (req[2]) win = 3'b100;
    return win;
  endfunction

  // The registered one-hot grant is converted to an index for the mux
  // selects. When idle the index defaults to 0, and every handshake output
  // is forced low anyway.
  always_comb begin
    g_idx = 2'd0;
    if (grant[1])      g_idx = 2'd1;
    else if (grant[2]) g_idx = 2'd2;
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    aw_fin      = 1'b0;
    w_fin       = 1'b0;
    m_awready   = 3'b000;
    m_wready    = 3'b000;
    m_bvalid    = 3'b000;
    s_awvalid   = 1'b0;
    s_wvalid    = 1'b0;
    s_bready    = 1'b0;
    // Data and response fields are always routed from the granted slice.
    // They carry meaning only while the matching valid is high.
    s_awaddr    = m_awaddr[g_idx*ADDR_W +: ADDR_W];
    s_wdata     = m_wdata[g_idx*DATA_W +: DATA_W];
    s_wstrb     = m_wstrb[g_idx*STRB_W +: STRB_W];
    m_bresp     = s_bresp;

    unique case (state)
      IDLE: begin
        // Only the registered grant drives the outputs, so m_awvalid has no
        // combinational path to any output while the switch is idle.
        if (|m_awvalid) begin
          grant_nxt = pick_winner(m_awvalid);
          state_nxt = XFER;
        end
      end
      XFER: begin
        s_awvalid        = m_awvalid[g_idx] & ~aw_done;
        m_awready[g_idx] = s_awready & ~aw_done;
        s_wvalid         = m_wvalid[g_idx] & ~w_done;
        m_wready[g_idx]  = s_wready & ~w_done;
        // A channel is finished once it has handshaken, either in an earlier
        // cycle or in this one. This lets the second channel move to RESP in
        // the same cycle that it completes.
        aw_fin      = aw_done | (s_awvalid & s_awready);
        w_fin       = w_done | (s_wvalid & s_wready);
        aw_done_nxt = aw_fin;
        w_done_nxt  = w_fin;
        if (aw_fin && w_fin) state_nxt = RESP;
      end
      RESP: begin
        m_bvalid[g_idx] = s_bvalid;
        s_bready        = m_bready[g_idx];
        if (s_bvalid && m_bready[g_idx]) begin
          state_nxt   = IDLE;
          grant_nxt   = 3'b000;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt   = IDLE;
        grant_nxt   = 3'b000;
        aw_done_nxt = 1'b0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= IDLE;
      grant   <= 3'b000;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_axi_lite_wr_switch_3to1.sv
module tb_axi_lite_wr_switch_3to1;

  logic        ACLK, ARESETN;
  logic [95:0] m_awaddr;
  logic [2:0]  m_awvalid, m_awready;
  logic [95:0] m_wdata;
  logic [11:0] m_wstrb;
  logic [2:0]  m_wvalid, m_wready;
  logic [1:0]  m_bresp;
  logic [2:0]  m_bvalid, m_bready;
  logic [31:0] s_awaddr;
  logic        s_awvalid, s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid, s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid, s_bready;
  logic [2:0]  grant;
  logic        busy;

  axi_lite_wr_switch_3to1 #(.ADDR_W(32), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .grant(grant), .busy(busy)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [1:0]  resp;
    int          br_dly;
  } vec_t;

  typedef struct {
    logic [2:0]  gnt;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[5];
  vec_t        post_rst;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cap_addr, cap_data;
  logic [3:0]  cap_strb;
  int          n_aw = 0;
  int          n_w = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout", name);
  endtask

  // Slave-side observer: captures forwarded beats and scores each B handshake
  // against the oldest expected write.
  task automatic monitor_step();
    exp_t e;
    if (!ARESETN) return;
    if (s_awvalid && s_awready) begin cap_addr = s_awaddr; n_aw++; end
    if (s_wvalid && s_wready) begin cap_data = s_wdata; cap_strb = s_wstrb; n_w++; end
    if (|(m_bvalid & m_bready)) begin
      if (sb.size() == 0) begin
        fail_now("sb_unexpected_b");
      end else begin
        e = sb.pop_front();
        chk("sb_bvalid_target", {29'd0, m_bvalid}, {29'd0, e.gnt});
        chk("sb_awaddr", cap_addr, e.addr);
        chk("sb_wdata", cap_data, e.data);
        chk("sb_wstrb", {28'd0, cap_strb}, {28'd0, e.strb});
        chk("sb_bresp", {30'd0, m_bresp}, {30'd0, e.resp});
        chk("sb_aw_beats", n_aw, 1);
        chk("sb_w_beats", n_w, 1);
      end
      n_aw = 0;
      n_w  = 0;
    end
  endtask

  task automatic tick_neg();
    @(negedge ACLK);
    monitor_step();
  endtask

  task automatic tick_pos();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] g, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] r);
    exp_t e;
    e.gnt = g; e.addr = a; e.data = d; e.strb = s; e.resp = r;
    sb.push_back(e);
  endtask

  // One write from a single master. Valids are held through RESP to prove
  // that the switch forwards only one beat per grant.
  task automatic run_vec(input vec_t v);
    logic [2:0] oh;
    int cyc;
    bit aw_ok, w_ok, b_ok;
    oh = 3'b001 << v.m;
    m_awaddr[v.m*32 +: 32] = v.addr;
    m_wdata[v.m*32 +: 32]  = v.data;
    m_wstrb[v.m*4 +: 4]    = v.strb;
    m_awvalid = oh;
    m_wvalid  = oh;
    m_bready  = 3'b000;
    push_exp(oh, v.addr, v.data, v.strb, v.resp);
    tick_neg();
    chk("arb_grant_idle", {29'd0, grant}, 32'd0);
    chk("arb_awready_idle", {29'd0, m_awready}, 32'd0);
    tick_pos();
    chk("grant_latched", {29'd0, grant}, {29'd0, oh});
    aw_ok = 0; w_ok = 0; cyc = 0;
    while (!(aw_ok && w_ok) && cyc < 40) begin
      s_awready = (cyc >= v.aw_dly);
      s_wready  = (cyc >= v.w_dly);
      tick_neg();
      chk("xfer_busy", {31'd0, busy}, 32'd1);
      if (aw_ok) begin
        chk("aw_gated_valid", {31'd0, s_awvalid}, 32'd0);
        chk("aw_gated_ready", {29'd0, m_awready}, 32'd0);
      end
      if (w_ok) begin
        chk("w_gated_valid", {31'd0, s_wvalid}, 32'd0);
        chk("w_gated_ready", {29'd0, m_wready}, 32'd0);
      end
      if (m_awvalid[v.m] && m_awready[v.m]) aw_ok = 1;
      if (m_wvalid[v.m] && m_wready[v.m]) w_ok = 1;
      tick_pos();
      cyc++;
    end
    if (!(aw_ok && w_ok)) fail_now("aw_w_handshake");
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b1;
    s_bresp   = v.resp;
    cyc = 0; b_ok = 0;
    while (!b_ok && cyc < 40) begin
      m_bready = (cyc >= v.br_dly) ? oh : 3'b000;
      tick_neg();
      chk("resp_busy", {31'd0, busy}, 32'd1);
      chk("resp_bvalid", {29'd0, m_bvalid}, {29'd0, oh});
      chk("resp_bresp", {30'd0, m_bresp}, {30'd0, v.resp});
      chk("resp_no_awvalid", {31'd0, s_awvalid}, 32'd0);
      chk("resp_grant", {29'd0, grant}, {29'd0, oh});
      if (m_bvalid[v.m] && m_bready[v.m]) b_ok = 1;
      tick_pos();
      cyc++;
    end
    if (!b_ok) fail_now("b_handshake");
    s_bvalid  = 1'b0;
    m_bready  = 3'b000;
    m_awvalid = 3'b000;
    m_wvalid  = 3'b000;
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("done_grant", {29'd0, grant}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    //          m  addr          data           strb  awd wd resp   brd
    vecs[0] = '{1, 32'h0000_1000, 32'hA5A5_0001, 4'hF, 0, 0, 2'b00, 0};
    vecs[1] = '{2, 32'h0000_2000, 32'h1234_5678, 4'h3, 3, 0, 2'b01, 1};
    vecs[2] = '{0, 32'h0000_3000, 32'hDEAD_BEEF, 4'h8, 0, 0, 2'b10, 4};
    vecs[3] = '{1, 32'h0000_4000, 32'h0BAD_F00D, 4'h6, 0, 2, 2'b11, 0};
    vecs[4] = '{0, 32'h0000_5000, 32'hCAFE_0005, 4'h1, 2, 2, 2'b00, 2};
    post_rst = '{2, 32'h0000_7000, 32'h7777_0007, 4'hC, 1, 0, 2'b00, 0};

    ARESETN   = 1'b0;
    m_awaddr  = '0; m_awvalid = '0; m_wdata = '0; m_wstrb = '0;
    m_wvalid  = '0; m_bready  = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = 2'b00; s_bvalid = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_grant", {29'd0, grant}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_awready", {29'd0, m_awready}, 32'd0);
    chk("rst_s_awvalid", {31'd0, s_awvalid}, 32'd0);
    chk("rst_s_bready", {31'd0, s_bready}, 32'd0);
    chk("rst_bvalid", {29'd0, m_bvalid}, 32'd0);
    ARESETN = 1'b1;
    tick_pos();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Contention: all three masters request together and are served 0, 1, 2.
    for (int i = 0; i < 3; i++) begin
      m_awaddr[i*32 +: 32] = 32'h10 * (i + 1);
      m_wdata[i*32 +: 32]  = 32'hD0 + i;
      m_wstrb[i*4 +: 4]    = 4'hF;
      push_exp(3'b001 << i, 32'h10 * (i + 1), 32'hD0 + i, 4'hF, 2'b00);
    end
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1; s_bresp = 2'b00;
    m_bready  = 3'b111;
    m_awvalid = 3'b111;
    m_wvalid  = 3'b111;
    for (int i = 0; i < 3; i++) begin
      tick_neg();
      chk("cont_idle_grant", {29'd0, grant}, 32'd0);
      chk("cont_idle_busy", {31'd0, busy}, 32'd0);
      tick_pos();
      chk("cont_grant", {29'd0, grant}, 32'd1 << i);
      tick_neg();
      chk("cont_awready", {29'd0, m_awready}, 32'd1 << i);
      chk("cont_wready", {29'd0, m_wready}, 32'd1 << i);
      chk("cont_awaddr", s_awaddr, 32'h10 * (i + 1));
      tick_pos();
      m_awvalid[i] = 1'b0;
      m_wvalid[i]  = 1'b0;
      chk("cont_resp_busy", {31'd0, busy}, 32'd1);
      tick_neg();
      chk("cont_bvalid", {29'd0, m_bvalid}, 32'd1 << i);
      tick_pos();
    end
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; m_bready = 3'b000;

    // Lock hold: master 0 requests while master 1 owns the switch.
    m_awaddr[32 +: 32] = 32'h0000_5100;
    m_wdata[32 +: 32]  = 32'h5151_5151;
    m_wstrb[4 +: 4]    = 4'hF;
    push_exp(3'b010, 32'h0000_5100, 32'h5151_5151, 4'hF, 2'b01);
    m_awvalid = 3'b010;
    m_wvalid  = 3'b010;
    tick_pos();
    chk("lock_grant0", {29'd0, grant}, 32'b010);
    m_awaddr[0 +: 32] = 32'h0000_6000;
    m_awvalid = 3'b011;
    s_awready = 1'b1;
    tick_neg();
    chk("lock_awready_first", {29'd0, m_awready}, 32'b010);
    chk("lock_awaddr", s_awaddr, 32'h0000_5100);
    for (int k = 0; k < 2; k++) begin
      tick_pos();
      tick_neg();
      chk("lock_grant_hold", {29'd0, grant}, 32'b010);
      chk("lock_awready_m0", {29'd0, m_awready}, 32'd0);
    end
    tick_pos();
    s_wready = 1'b1;
    tick_neg();
    chk("lock_wready", {29'd0, m_wready}, 32'b010);
    tick_pos();
    s_awready = 1'b0; s_wready = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'b01; m_bready = 3'b000;
    tick_neg();
    chk("lock_resp_grant", {29'd0, grant}, 32'b010);
    chk("lock_resp_awready", {29'd0, m_awready}, 32'd0);
    chk("lock_resp_bvalid", {29'd0, m_bvalid}, 32'b010);
    tick_pos();
    m_bready = 3'b010;
    tick_neg();
    tick_pos();
    m_awvalid = 3'b001;
    m_wvalid  = 3'b000;
    m_bready  = 3'b000;
    s_bvalid  = 1'b0;
    chk("lock_after_b_grant", {29'd0, grant}, 32'd0);
    chk("lock_after_b_busy", {31'd0, busy}, 32'd0);
    tick_pos();
    chk("next_grant_m0", {29'd0, grant}, 32'b001);
    chk("pre_rst_s_awvalid", {31'd0, s_awvalid}, 32'd1);

    // Asynchronous reset in the middle of a cycle abandons master 0's write.
    #2;
    ARESETN = 1'b0;
    #1;
    chk("arst_grant", {29'd0, grant}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_s_awvalid", {31'd0, s_awvalid}, 32'd0);
    chk("arst_s_wvalid", {31'd0, s_wvalid}, 32'd0);
    chk("arst_awready", {29'd0, m_awready}, 32'd0);
    chk("arst_wready", {29'd0, m_wready}, 32'd0);
    chk("arst_bvalid", {29'd0, m_bvalid}, 32'd0);
    chk("arst_s_bready", {31'd0, s_bready}, 32'd0);
    m_awvalid = 3'b000;
    n_aw = 0;
    n_w  = 0;
    tick_pos();
    ARESETN = 1'b1;
    tick_pos();
    run_vec(post_rst);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_wr_switch_3to1.md
Name: axi_lite_wr_switch_3to1

Overview:
- Write-path switch that routes one of three AXI4-Lite write masters onto a single slave port.
- Upstream of it, master AWVALIDs form a 3-bit fixed-priority request vector; the same priority rule is computed inside this block.
- It registers the winner and locks the AW, W and B channels to that master until the write response completes.
- Sits between master-side interfaces and the single slave in the interconnect write path.

Parameters:
- ADDR_W, 32, address width per master.
- DATA_W, 32, data width per master; STRB_W = DATA_W/8, derived.

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- m_awaddr  in  3*ADDR_W  master i occupies slice [i*ADDR_W +: ADDR_W].
- m_awvalid  in  3  per-master AWVALID; also the request vector.
- m_awready  out  3  per-master AWREADY.
- m_wdata  in  3*DATA_W  per-master WDATA slices.
- m_wstrb  in  3*STRB_W  per-master WSTRB slices.
- m_wvalid  in  3  per-master WVALID.
- m_wready  out  3  per-master WREADY.
- m_bresp  out  2  BRESP, broadcast to all masters; meaningful only with BVALID.
- m_bvalid  out  3  per-master BVALID.
- m_bready  in  3  per-master BREADY.
- s_awaddr/s_awvalid/s_awready  out/out/in  ADDR_W/1/1  slave AW channel.
- s_wdata/s_wstrb/s_wvalid/s_wready  out/out/out/in  DATA_W/STRB_W/1/1  slave W channel.
- s_bresp/s_bvalid/s_bready  in/in/out  2/1/1  slave B channel.
- grant  out  3  registered one-hot lock, 000 when idle.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Priority rule: bit 0 > bit 1 > bit 2. Winner is the lowest-index set bit of m_awvalid; 000 means no grant. No fairness: starvation of masters 1/2 is permitted.
- Reset (ARESETN low, asynchronous):
  - state=IDLE, grant=000, aw_done=w_done=0.
  - All m_*ready, m_bvalid, s_*valid, s_bready = 0.
  - Reset mid-transaction abandons the transaction; no response is returned to the master.
- State IDLE:
  - All handshake outputs 0.
  - If m_awvalid != 0, register the one-hot winner into grant and go to XFER next edge.
  - Arbitration costs exactly 1 cycle.
- State XFER (routing is combinational from the registered grant index g):
  - s_awaddr = m_awaddr[g]; s_awvalid = m_awvalid[g] & ~aw_done; m_awready[g] = s_awready & ~aw_done.
  - W channel routed identically, gated by ~w_done.
  - Non-granted masters see ready = 0.
  - aw_done sets on the s_aw handshake; w_done sets on the s_w handshake. AW and W may complete in either order or in the same cycle.
  - Exactly one AW and one W beat are passed per grant.
  - When both done (including same-cycle completion of the last one), go to RESP next edge.
- State RESP:
  - m_bvalid[g] = s_bvalid; m_bresp = s_bresp; s_bready = m_bready[g].
  - On the B handshake: clear grant, aw_done and w_done; go to IDLE.
- Back-to-back writes: minimum of 1 idle/arbitration cycle between a B handshake and the next AW grant.
- Outputs never depend combinationally on m_awvalid in IDLE; there are no comb loops valid→ready.
- A request change by a non-granted master during XFER/RESP has no effect on the locked grant.
- Slave-driven s_bresp (OKAY/SLVERR, etc.) is passed through unmodified.

Test Plan:
- Single master: m_awvalid=010, AW+W presented, slave accepts both in 1 cycle, BRESP=00 → grant=010 one cycle after request; m_awready[1] and m_wready[1] pulse; m_bvalid=010; busy drops after the B handshake.
- Contention: m_awvalid=111 in the same cycle → grant=001. After the B handshake: IDLE 1 cycle, then grant=010, then grant=100. Addresses 0x10/0x20/0x30 appear on s_awaddr in that order.
- W before AW: master 2 alone, s_wready=1 while s_awready is held 0 for 3 cycles → w_done first; s_wvalid drops after 1 beat; RESP entered only after the AW handshake.
- Backpressure on B: s_bvalid=1 with BRESP=10, m_bready[0]=0 for 4 cycles → state held in RESP; m_bresp=10 stable; exit on the cycle m_bready[0]=1.
- Lock hold: master 1 granted, master 0 raises m_awvalid mid-XFER → grant stays 010; m_awready[0]=0 until master 1's B completes.
- Async reset: assert ARESETN=0 in XFER between clock edges → grant=000, busy=0 and all valid/ready outputs 0 immediately. After release, a fresh request is granted normally.
